// File: rtl/alu_reservation_station_pkg.sv
// Shared constants, op classes and storage types for the ALU reservation station.
package alu_reservation_station_pkg;

  localparam int RS_SIZE = 8;
  localparam int RS_BIT  = 3;
  localparam int ROB_BIT = 4;

  // Major opcode classes handled by this station (RV32I opcode field).
  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE    = 7'b0010011;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] JALR_TYPE = 7'b1100111;
  localparam logic [6:0] LUI_TYPE  = 7'b0110111;
  localparam logic [6:0] AUIPC_TYPE = 7'b0010111;

  // One waiting instruction. Busy lives in a separate vector.
  typedef struct packed {
    logic [6:0]         op_type;
    logic [6:0]         op;
    logic [ROB_BIT-1:0] rob;
    logic [31:0]        pc;
    logic [31:0]        imm;
    logic [31:0]        vj;
    logic               qj_busy;
    logic [ROB_BIT-1:0] qj;
    logic [31:0]        vk;
    logic               qk_busy;
    logic [ROB_BIT-1:0] qk;
  } rs_entry_t;

  // Registered dispatch payload towards the ALU.
  typedef struct packed {
    logic [6:0]         op_type;
    logic [6:0]         op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic [31:0]        imm;
    logic [31:0]        pc;
    logic [ROB_BIT-1:0] rob;
  } alu_out_t;

  // True when a valid broadcast carries the tag an operand is waiting for.
  function automatic logic tag_hit(input logic valid, input logic [ROB_BIT-1:0] bus_tag,
                                   input logic [ROB_BIT-1:0] want_tag);
    return valid && (bus_tag == want_tag);
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Issue, CDB and ALU-dispatch signal bundle around the reservation station.
//
// Handshake semantics: issue_valid is a one-cycle request that is consumed on
// the same edge it is sampled; there is no ready, so the issuer must check
// rs_full (combinational, from registered state) before raising issue_valid.
// cdb_*_valid and alu_valid are pure one-cycle broadcasts with no back-pressure.
interface alu_reservation_station_if;
  import alu_reservation_station_pkg::*;

  logic               issue_valid;
  logic [6:0]         issue_op_type;
  logic [6:0]         issue_op;
  logic [ROB_BIT-1:0] issue_rob_entry;
  logic [31:0]        issue_pc;
  logic [31:0]        issue_imm;
  logic [31:0]        issue_vj;
  logic               issue_qj_busy;
  logic [ROB_BIT-1:0] issue_qj;
  logic [31:0]        issue_vk;
  logic               issue_qk_busy;
  logic [ROB_BIT-1:0] issue_qk;

  logic               cdb_alu_valid;
  logic [ROB_BIT-1:0] cdb_alu_entry;
  logic [31:0]        cdb_alu_value;
  logic               cdb_lsb_valid;
  logic [ROB_BIT-1:0] cdb_lsb_entry;
  logic [31:0]        cdb_lsb_value;

  logic               rs_full;
  logic               alu_valid;
  logic [6:0]         alu_op_type;
  logic [6:0]         alu_op;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [31:0]        alu_imm;
  logic [31:0]        alu_pc;
  logic [ROB_BIT-1:0] alu_rob_entry;

  // Issue/CDB side: drives requests and broadcasts, observes station outputs.
  modport master (
    output issue_valid, issue_op_type, issue_op, issue_rob_entry, issue_pc, issue_imm,
           issue_vj, issue_qj_busy, issue_qj, issue_vk, issue_qk_busy, issue_qk,
           cdb_alu_valid, cdb_alu_entry, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_entry, cdb_lsb_value,
    input  rs_full, alu_valid, alu_op_type, alu_op, alu_a, alu_b, alu_imm, alu_pc,
           alu_rob_entry
  );

  // Station side.
  modport slave (
    input  issue_valid, issue_op_type, issue_op, issue_rob_entry, issue_pc, issue_imm,
           issue_vj, issue_qj_busy, issue_qj, issue_vk, issue_qk_busy, issue_qk,
           cdb_alu_valid, cdb_alu_entry, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_entry, cdb_lsb_value,
    output rs_full, alu_valid, alu_op_type, alu_op, alu_a, alu_b, alu_imm, alu_pc,
           alu_rob_entry
  );

endinterface

// File: rtl/alu_reservation_station_rs_priority_enc.sv
// Lowest-set-bit finder: index of the lowest asserted bit plus a found flag.
module rs_priority_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station for ALU/branch/JALR ops: holds instructions until both
// operands arrive via the CDBs, then dispatches the lowest ready entry.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear,
  alu_reservation_station_if.slave  bus,
  output logic [RS_SIZE-1:0]        dbg_busy_o
);

  logic [RS_SIZE-1:0]               busy_q, busy_d;
  rs_entry_t [RS_SIZE-1:0]          ent_q, ent_d;
  alu_out_t                         alu_q, alu_d;
  logic                             alu_valid_q, alu_valid_d;

  logic [RS_SIZE-1:0]               free_vec, ready_vec;
  logic [RS_BIT-1:0]                free_idx, rdy_idx;
  logic                             free_found, rdy_found;
  rs_entry_t                        new_ent;

  // Free/ready vectors come from registered state only, so a slot freed by
  // dispatch this cycle is not reusable until the next one.
  always_comb begin
    free_vec  = ~busy_q;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
    end
  end

  rs_priority_enc #(.N(RS_SIZE), .W(RS_BIT)) u_free_enc (
    .vec_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_priority_enc #(.N(RS_SIZE), .W(RS_BIT)) u_ready_enc (
    .vec_i   (ready_vec),
    .idx_o   (rdy_idx),
    .found_o (rdy_found)
  );

  // Build the incoming entry, forwarding a same-cycle CDB value into a waiting operand.
  always_comb begin
    new_ent.op_type = bus.issue_op_type;
    new_ent.op      = bus.issue_op;
    new_ent.rob     = bus.issue_rob_entry;
    new_ent.pc      = bus.issue_pc;
    new_ent.imm     = bus.issue_imm;
    new_ent.vj      = bus.issue_vj;
    new_ent.qj_busy = bus.issue_qj_busy;
    new_ent.qj      = bus.issue_qj;
    new_ent.vk      = bus.issue_vk;
    new_ent.qk_busy = bus.issue_qk_busy;
    new_ent.qk      = bus.issue_qk;
    if (bus.issue_qj_busy) begin
      if (tag_hit(bus.cdb_alu_valid, bus.cdb_alu_entry, bus.issue_qj)) begin
        new_ent.vj      = bus.cdb_alu_value;
        new_ent.qj_busy = 1'b0;
      end else if (tag_hit(bus.cdb_lsb_valid, bus.cdb_lsb_entry, bus.issue_qj)) begin
        new_ent.vj      = bus.cdb_lsb_value;
        new_ent.qj_busy = 1'b0;
      end
    end
    if (bus.issue_qk_busy) begin
      if (tag_hit(bus.cdb_alu_valid, bus.cdb_alu_entry, bus.issue_qk)) begin
        new_ent.vk      = bus.cdb_alu_value;
        new_ent.qk_busy = 1'b0;
      end else if (tag_hit(bus.cdb_lsb_valid, bus.cdb_lsb_entry, bus.issue_qk)) begin
        new_ent.vk      = bus.cdb_lsb_value;
        new_ent.qk_busy = 1'b0;
      end
    end
  end

  // Next state: freeze on !rdy_in, flush on clear, else snoop/dispatch/issue.
  always_comb begin
    busy_d      = busy_q;
    ent_d       = ent_q;
    alu_d       = alu_q;
    alu_valid_d = alu_valid_q;
    if (rdy_in) begin
      if (clear) begin
        busy_d      = '0;
        alu_valid_d = 1'b0;
      end else begin
        // Wakeup: each waiting operand captures a matching broadcast.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && ent_q[i].qj_busy) begin
            if (tag_hit(bus.cdb_alu_valid, bus.cdb_alu_entry, ent_q[i].qj)) begin
              ent_d[i].vj      = bus.cdb_alu_value;
              ent_d[i].qj_busy = 1'b0;
            end else if (tag_hit(bus.cdb_lsb_valid, bus.cdb_lsb_entry, ent_q[i].qj)) begin
              ent_d[i].vj      = bus.cdb_lsb_value;
              ent_d[i].qj_busy = 1'b0;
            end
          end
          if (busy_q[i] && ent_q[i].qk_busy) begin
            if (tag_hit(bus.cdb_alu_valid, bus.cdb_alu_entry, ent_q[i].qk)) begin
              ent_d[i].vk      = bus.cdb_alu_value;
              ent_d[i].qk_busy = 1'b0;
            end else if (tag_hit(bus.cdb_lsb_valid, bus.cdb_lsb_entry, ent_q[i].qk)) begin
              ent_d[i].vk      = bus.cdb_lsb_value;
              ent_d[i].qk_busy = 1'b0;
            end
          end
        end
        // Dispatch: data outputs hold their last values when nothing is ready.
        alu_valid_d = rdy_found;
        if (rdy_found) begin
          alu_d.op_type   = ent_q[rdy_idx].op_type;
          alu_d.op        = ent_q[rdy_idx].op;
          alu_d.a         = ent_q[rdy_idx].vj;
          alu_d.b         = ent_q[rdy_idx].vk;
          alu_d.imm       = ent_q[rdy_idx].imm;
          alu_d.pc        = ent_q[rdy_idx].pc;
          alu_d.rob       = ent_q[rdy_idx].rob;
          busy_d[rdy_idx] = 1'b0;
        end
        // Issue into the lowest free slot; dropped when the station is full.
        if (bus.issue_valid && free_found) begin
          busy_d[free_idx] = 1'b1;
          ent_d[free_idx]  = new_ent;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      ent_q       <= '0;
      alu_q       <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      ent_q       <= ent_d;
      alu_q       <= alu_d;
      alu_valid_q <= alu_valid_d;
    end
  end

  assign bus.rs_full       = &busy_q;
  assign bus.alu_valid     = alu_valid_q;
  assign bus.alu_op_type   = alu_q.op_type;
  assign bus.alu_op        = alu_q.op;
  assign bus.alu_a         = alu_q.a;
  assign bus.alu_b         = alu_q.b;
  assign bus.alu_imm       = alu_q.imm;
  assign bus.alu_pc        = alu_q.pc;
  assign bus.alu_rob_entry = alu_q.rob;
  assign dbg_busy_o        = busy_q;

  // The issuer must never present an instruction while the station is full.
  issue_when_full_a: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && !clear && bus.issue_valid) |-> !bus.rs_full);

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with a queue-based dispatch scoreboard.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int EW = 7 + 7 + ROB_BIT + 32 * 4;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               rdy_in = 1'b1;
  logic               clear  = 1'b0;
  logic [RS_SIZE-1:0] dbg_busy;

  alu_reservation_station_if rs_if();

  alu_reservation_station dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .bus        (rs_if),
    .dbg_busy_o (dbg_busy)
  );

  // Clock and watchdog.
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] pack(input logic [6:0] op_type, input logic [6:0] op,
                                         input logic [ROB_BIT-1:0] rob, input logic [31:0] pc,
                                         input logic [31:0] imm, input logic [31:0] a,
                                         input logic [31:0] b);
    return {op_type, op, rob, pc, imm, a, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rs_if.issue_valid   = 1'b0;
    rs_if.cdb_alu_valid = 1'b0;
    rs_if.cdb_lsb_valid = 1'b0;
  endtask

  task automatic put_issue(input logic [6:0] op_type, input logic [6:0] op,
                           input logic [ROB_BIT-1:0] rob, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] vj, input logic qjb,
                           input logic [ROB_BIT-1:0] qj, input logic [31:0] vk,
                           input logic qkb, input logic [ROB_BIT-1:0] qk);
    rs_if.issue_valid     = 1'b1;
    rs_if.issue_op_type   = op_type;
    rs_if.issue_op        = op;
    rs_if.issue_rob_entry = rob;
    rs_if.issue_pc        = pc;
    rs_if.issue_imm       = imm;
    rs_if.issue_vj        = vj;
    rs_if.issue_qj_busy   = qjb;
    rs_if.issue_qj        = qj;
    rs_if.issue_vk        = vk;
    rs_if.issue_qk_busy   = qkb;
    rs_if.issue_qk        = qk;
  endtask

  task automatic cdb_alu(input logic [ROB_BIT-1:0] tag, input logic [31:0] val);
    rs_if.cdb_alu_valid = 1'b1;
    rs_if.cdb_alu_entry = tag;
    rs_if.cdb_alu_value = val;
  endtask

  task automatic cdb_lsb(input logic [ROB_BIT-1:0] tag, input logic [31:0] val);
    rs_if.cdb_lsb_valid = 1'b1;
    rs_if.cdb_lsb_entry = tag;
    rs_if.cdb_lsb_value = val;
  endtask

  // Wait for every expected dispatch to be seen, within a cycle budget.
  task automatic drain(input string name);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending dispatches expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor: every dispatch pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (!rst_in && rs_if.alu_valid) begin
      logic [EW-1:0] act;
      act = pack(rs_if.alu_op_type, rs_if.alu_op, rs_if.alu_rob_entry, rs_if.alu_pc,
                 rs_if.alu_imm, rs_if.alu_a, rs_if.alu_b);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dispatch: got %0h expected no dispatch", act);
      end else begin
        logic [EW-1:0] exp;
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL dispatch: got %0h expected %0h", act, exp);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    idle();
    put_issue(7'd0, 7'd0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    idle();
    cdb_alu('0, '0);
    cdb_lsb('0, '0);
    idle();
    repeat (2) tick();
    check("reset_alu_valid", 32'(rs_if.alu_valid), 32'd0);
    check("reset_rs_full", 32'(rs_if.rs_full), 32'd0);
    check("reset_busy", 32'(dbg_busy), 32'd0);
    check("reset_alu_a", rs_if.alu_a, 32'd0);
    rst_in = 1'b0;
    tick();

    // Ready issue: 2 edges to alu_valid.
    put_issue(R_TYPE, 7'd0, 4'd3, 32'h100, 32'd0, 32'd5, 1'b0, '0, 32'd7, 1'b0, '0);
    exp_q.push_back(pack(R_TYPE, 7'd0, 4'd3, 32'h100, 32'd0, 32'd5, 32'd7));
    tick();
    idle();
    check("ready_rs_full", 32'(rs_if.rs_full), 32'd0);
    check("ready_busy", 32'(dbg_busy), 32'h01);
    check("ready_not_yet", 32'(rs_if.alu_valid), 32'd0);
    tick();
    check("ready_latency", 32'(rs_if.alu_valid), 32'd1);
    tick();
    check("ready_pulse_end", 32'(rs_if.alu_valid), 32'd0);
    check("ready_freed", 32'(dbg_busy), 32'd0);
    drain("ready");

    // Wakeup on ALU CDB after 3 idle cycles.
    put_issue(R_TYPE, 7'd1, 4'd4, 32'h104, 32'd0, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, '0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wakeup_wait", 32'(rs_if.alu_valid), 32'd0);
    end
    cdb_alu(4'd2, 32'h1234);
    exp_q.push_back(pack(R_TYPE, 7'd1, 4'd4, 32'h104, 32'd0, 32'h1234, 32'd1));
    tick();
    idle();
    check("wakeup_capture_edge", 32'(rs_if.alu_valid), 32'd0);
    tick();
    check("wakeup_dispatch", 32'(rs_if.alu_valid), 32'd1);
    drain("wakeup");

    // Both CDBs wake different operands of one entry in the same cycle.
    put_issue(B_TYPE, 7'd2, 4'd6, 32'h108, 32'h40, 32'd0, 1'b1, 4'd5, 32'd0, 1'b1, 4'd7);
    tick();
    idle();
    cdb_alu(4'd5, 32'hA);
    cdb_lsb(4'd7, 32'hB);
    exp_q.push_back(pack(B_TYPE, 7'd2, 4'd6, 32'h108, 32'h40, 32'hA, 32'hB));
    tick();
    idle();
    tick();
    check("dual_cdb_dispatch", 32'(rs_if.alu_valid), 32'd1);
    drain("dual_cdb");

    // Issue-time forwarding from the LSB CDB.
    put_issue(JALR_TYPE, 7'd0, 4'd5, 32'h10C, 32'h8, 32'h11, 1'b0, '0, 32'd0, 1'b1, 4'd6);
    cdb_lsb(4'd6, 32'hDEAD);
    exp_q.push_back(pack(JALR_TYPE, 7'd0, 4'd5, 32'h10C, 32'h8, 32'h11, 32'hDEAD));
    tick();
    idle();
    tick();
    check("forward_dispatch", 32'(rs_if.alu_valid), 32'd1);
    drain("forward");

    // Fill all 8 entries on tag 9, then release them with one broadcast.
    for (int i = 0; i < RS_SIZE; i++) begin
      put_issue(I_TYPE, 7'(i), 4'(i), 32'h200 + 32'(4 * i), 32'(i), 32'd0, 1'b1, 4'd9,
                32'(i), 1'b0, '0);
      tick();
    end
    idle();
    check("full_rs_full", 32'(rs_if.rs_full), 32'd1);
    check("full_busy", 32'(dbg_busy), 32'hFF);
    cdb_alu(4'd9, 32'h99);
    for (int i = 0; i < RS_SIZE; i++) begin
      exp_q.push_back(pack(I_TYPE, 7'(i), 4'(i), 32'h200 + 32'(4 * i), 32'(i), 32'h99, 32'(i)));
    end
    tick();
    idle();
    check("full_still_full", 32'(rs_if.rs_full), 32'd1);
    tick();
    check("full_released", 32'(rs_if.rs_full), 32'd0);
    check("full_first_dispatch", 32'(rs_if.alu_valid), 32'd1);
    drain("full");

    // Flush with 4 pending entries and a concurrent issue.
    for (int i = 0; i < 4; i++) begin
      put_issue(R_TYPE, 7'd3, 4'(8 + i), 32'h300, 32'd0, 32'd0, 1'b1, 4'd12, 32'd1, 1'b0, '0);
      tick();
    end
    idle();
    check("flush_pending", 32'(dbg_busy), 32'h0F);
    clear = 1'b1;
    put_issue(R_TYPE, 7'd4, 4'd13, 32'h310, 32'd0, 32'd1, 1'b0, '0, 32'd2, 1'b0, '0);
    tick();
    clear = 1'b0;
    idle();
    check("flush_busy", 32'(dbg_busy), 32'd0);
    check("flush_alu_valid", 32'(rs_if.alu_valid), 32'd0);
    check("flush_rs_full", 32'(rs_if.rs_full), 32'd0);
    cdb_alu(4'd12, 32'h77);
    tick();
    idle();
    tick();
    check("flush_no_dispatch", 32'(rs_if.alu_valid), 32'd0);
    check("flush_stays_empty", 32'(dbg_busy), 32'd0);

    // Stall: rdy_in low for 5 cycles after the operand is captured.
    put_issue(R_TYPE, 7'd5, 4'd1, 32'h400, 32'd0, 32'd0, 1'b1, 4'd3, 32'd2, 1'b0, '0);
    tick();
    idle();
    cdb_alu(4'd3, 32'h55);
    exp_q.push_back(pack(R_TYPE, 7'd5, 4'd1, 32'h400, 32'd0, 32'h55, 32'd2));
    tick();
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_dispatch", 32'(rs_if.alu_valid), 32'd0);
      check("stall_busy_held", 32'(dbg_busy), 32'h01);
    end
    rdy_in = 1'b1;
    tick();
    check("stall_resume_dispatch", 32'(rs_if.alu_valid), 32'd1);
    check("stall_resume_freed", 32'(dbg_busy), 32'd0);
    drain("stall");

    // Asynchronous reset while alu_valid is high.
    put_issue(R_TYPE, 7'd6, 4'd2, 32'h500, 32'd0, 32'h21, 1'b0, '0, 32'h22, 1'b0, '0);
    exp_q.push_back(pack(R_TYPE, 7'd6, 4'd2, 32'h500, 32'd0, 32'h21, 32'h22));
    tick();
    idle();
    tick();
    check("pre_reset_valid", 32'(rs_if.alu_valid), 32'd1);
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    check("async_reset_valid", 32'(rs_if.alu_valid), 32'd0);
    check("async_reset_alu_a", rs_if.alu_a, 32'd0);
    check("async_reset_rob", 32'(rs_if.alu_rob_entry), 32'd0);
    tick();
    rst_in = 1'b0;
    tick();
    drain("reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
